// File: rtl/cle_pkg.sv
// Shared constants, FSM state encoding and component-table slot layout for the
// label statistics engine.
package cle_pkg;

    localparam int IMG_W   = 32;
    localparam int ADDR_W  = 10;
    localparam int LABEL_W = 8;
    localparam int AREA_W  = 11;
    localparam int COORD_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [LABEL_W-1:0] label;
        logic [AREA_W-1:0]  area;
        logic [COORD_W-1:0] rmin;
        logic [COORD_W-1:0] rmax;
        logic [COORD_W-1:0] cmin;
        logic [COORD_W-1:0] cmax;
    } slot_t;

endpackage

// File: rtl/cle_label_cam.sv
// Parallel label match over all table slots; also reports the lowest free slot.
module cle_label_cam
    import cle_pkg::*;
#(
    parameter int MAX_LABELS = 32,
    parameter int SEL_W      = 5
) (
    input  logic [MAX_LABELS-1:0]              valid_i,
    input  logic [MAX_LABELS-1:0][LABEL_W-1:0] label_i,
    input  logic [LABEL_W-1:0]                 key_i,
    output logic                               hit_o,
    output logic [SEL_W-1:0]                   hit_idx_o,
    output logic                               free_vld_o,
    output logic [SEL_W-1:0]                   free_idx_o
);

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        hit_o      = 1'b0;
        hit_idx_o  = '0;
        free_vld_o = 1'b0;
        free_idx_o = '0;
        for (int i = MAX_LABELS - 1; i >= 0; i--) begin
            if (valid_i[i] && (label_i[i] == key_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = SEL_W'(i);
            end
            if (!valid_i[i]) begin
                free_vld_o = 1'b1;
                free_idx_o = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/cle_label_stats.sv
// Scans the 32x32 label SRAM once per start and builds a per-label table of
// area and bounding box, readable through a combinational slot select.
module cle_label_stats
    import cle_pkg::*;
#(
    parameter int MAX_LABELS = 32,
    parameter int SEL_W      = $clog2(MAX_LABELS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LABEL_W-1:0] sram_q,
    output logic [ADDR_W-1:0]  sram_a,
    output logic               sram_wen,
    input  logic [SEL_W-1:0]   stat_sel,
    output logic [LABEL_W-1:0] stat_label,
    output logic [AREA_W-1:0]  stat_area,
    output logic [COORD_W-1:0] stat_rmin,
    output logic [COORD_W-1:0] stat_rmax,
    output logic [COORD_W-1:0] stat_cmin,
    output logic [COORD_W-1:0] stat_cmax,
    output logic [SEL_W:0]     num_labels,
    output logic               overflow,
    output logic               busy,
    output logic               done,
    output state_t             dbg_state
);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                busy_q, done_q;
    logic                p0_vld_q, p1_vld_q;
    logic [ADDR_W-1:0]   p1_addr_q;

    slot_t               slot_q [MAX_LABELS];
    slot_t               slot_d [MAX_LABELS];
    logic [SEL_W:0]      num_q, num_d;
    logic                ovf_q, ovf_d;

    logic [MAX_LABELS-1:0]              cam_valid;
    logic [MAX_LABELS-1:0][LABEL_W-1:0] cam_label;
    logic                               cam_hit, cam_free_vld;
    logic [SEL_W-1:0]                   cam_hit_idx, cam_free_idx;

    logic                clear;
    logic [COORD_W-1:0]  pix_row, pix_col;
    slot_t               upd;
    slot_t               sel_slot;

    // p0 marks an address issued this cycle; p1 marks its data arriving on sram_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            p0_vld_q  <= 1'b0;
            p1_vld_q  <= 1'b0;
            p1_addr_q <= '0;
        end else begin
            p1_vld_q  <= p0_vld_q;
            p1_addr_q <= addr_q;
            p0_vld_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q  <= ST_SCAN;
                        addr_q   <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        p0_vld_q <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    addr_q   <= addr_q + ADDR_W'(1);
                    p0_vld_q <= 1'b1;
                    if (addr_q == ADDR_W'(IMG_W * IMG_W - 2)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (p1_vld_q && !p0_vld_q) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < MAX_LABELS; g++) begin : g_cam_in
        assign cam_valid[g] = slot_q[g].valid;
        assign cam_label[g] = slot_q[g].label;
    end

    cle_label_cam #(
        .MAX_LABELS (MAX_LABELS),
        .SEL_W      (SEL_W)
    ) u_cam (
        .valid_i    (cam_valid),
        .label_i    (cam_label),
        .key_i      (sram_q),
        .hit_o      (cam_hit),
        .hit_idx_o  (cam_hit_idx),
        .free_vld_o (cam_free_vld),
        .free_idx_o (cam_free_idx)
    );

    assign clear   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign pix_row = p1_addr_q[ADDR_W-1:COORD_W];
    assign pix_col = p1_addr_q[COORD_W-1:0];

    // Match and allocate are resolved combinationally so back-to-back pixels
    // of the same label see the previous update.
    always_comb begin
        slot_d = slot_q;
        num_d  = num_q;
        ovf_d  = ovf_q;
        upd    = '0;
        if (clear) begin
            for (int i = 0; i < MAX_LABELS; i++) begin
                slot_d[i] = '0;
            end
            num_d = '0;
            ovf_d = 1'b0;
        end else if (p1_vld_q && (sram_q != '0)) begin
            if (cam_hit) begin
                upd      = slot_q[cam_hit_idx];
                upd.area = upd.area + AREA_W'(1);
                if (pix_row < upd.rmin) upd.rmin = pix_row;
                if (pix_row > upd.rmax) upd.rmax = pix_row;
                if (pix_col < upd.cmin) upd.cmin = pix_col;
                if (pix_col > upd.cmax) upd.cmax = pix_col;
                slot_d[cam_hit_idx] = upd;
            end else if (cam_free_vld) begin
                upd.valid = 1'b1;
                upd.label = sram_q;
                upd.area  = AREA_W'(1);
                upd.rmin  = pix_row;
                upd.rmax  = pix_row;
                upd.cmin  = pix_col;
                upd.cmax  = pix_col;
                slot_d[cam_free_idx] = upd;
                num_d = num_q + (SEL_W + 1)'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LABELS; i++) begin
                slot_q[i] <= '0;
            end
            num_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            num_q  <= num_d;
            ovf_q  <= ovf_d;
        end
    end

    assign sel_slot = ({1'b0, stat_sel} < num_q) ? slot_q[stat_sel] : '0;

    assign stat_label = sel_slot.label;
    assign stat_area  = sel_slot.area;
    assign stat_rmin  = sel_slot.rmin;
    assign stat_rmax  = sel_slot.rmax;
    assign stat_cmin  = sel_slot.cmin;
    assign stat_cmax  = sel_slot.cmax;

    assign sram_a     = addr_q;
    assign sram_wen   = 1'b1;
    assign num_labels = num_q;
    assign overflow   = ovf_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_cle_label_stats.sv
// Bench for cle_label_stats: SRAM model, raster-order reference table and
// slot-by-slot readout comparison for directed and random images.
module tb_cle_label_stats;
    import cle_pkg::*;

    localparam int MAXL = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [7:0]   sram_q;
    logic [9:0]   sram_a;
    logic         sram_wen;
    logic [4:0]   stat_sel;
    logic [7:0]   stat_label;
    logic [10:0]  stat_area;
    logic [4:0]   stat_rmin, stat_rmax, stat_cmin, stat_cmax;
    logic [5:0]   num_labels;
    logic         overflow, busy, done;
    state_t       dbg_state;

    cle_label_stats #(.MAX_LABELS(MAXL), .SEL_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sram_q     (sram_q),
        .sram_a     (sram_a),
        .sram_wen   (sram_wen),
        .stat_sel   (stat_sel),
        .stat_label (stat_label),
        .stat_area  (stat_area),
        .stat_rmin  (stat_rmin),
        .stat_rmax  (stat_rmax),
        .stat_cmin  (stat_cmin),
        .stat_cmax  (stat_cmax),
        .num_labels (num_labels),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // label SRAM: data appears the cycle after the address is sampled
    logic [7:0] mem [1024];
    always @(posedge clk) sram_q <= mem[sram_a];

    // scoreboard
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [38:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference model: walk the image in raster order, first appearance allocates
    int        ref_n;
    bit        ref_ovf;
    logic [7:0] r_lbl [MAXL];
    int        r_area [MAXL];
    int        r_rmin [MAXL], r_rmax [MAXL], r_cmin [MAXL], r_cmax [MAXL];

    task automatic build_ref();
        int r, c, j, found;
        ref_n   = 0;
        ref_ovf = 0;
        for (int a = 0; a < 1024; a++) begin
            if (mem[a] == 8'h00) continue;
            r = a / 32;
            c = a % 32;
            found = -1;
            for (j = 0; j < ref_n; j++) if (r_lbl[j] == mem[a]) found = j;
            if (found >= 0) begin
                r_area[found]++;
                if (r < r_rmin[found]) r_rmin[found] = r;
                if (r > r_rmax[found]) r_rmax[found] = r;
                if (c < r_cmin[found]) r_cmin[found] = c;
                if (c > r_cmax[found]) r_cmax[found] = c;
            end else if (ref_n < MAXL) begin
                r_lbl[ref_n]  = mem[a];
                r_area[ref_n] = 1;
                r_rmin[ref_n] = r; r_rmax[ref_n] = r;
                r_cmin[ref_n] = c; r_cmax[ref_n] = c;
                ref_n++;
            end else begin
                ref_ovf = 1;
            end
        end
        exp_q.delete();
        for (int s = 0; s < MAXL; s++) begin
            if (s < ref_n)
                exp_q.push_back({r_lbl[s], 11'(r_area[s]), 5'(r_rmin[s]), 5'(r_rmax[s]),
                                 5'(r_cmin[s]), 5'(r_cmax[s])});
            else
                exp_q.push_back('0);
        end
    endtask

    task automatic check_table(input string tag);
        logic [38:0] exp;
        check({tag, ":num"}, num_labels, ref_n);
        check({tag, ":ovf"}, overflow, ref_ovf);
        for (int s = 0; s < MAXL; s++) begin
            stat_sel = 5'(s);
            #1;
            exp = exp_q.pop_front();
            check($sformatf("%s:slot%0d", tag, s),
                  {stat_label, stat_area, stat_rmin, stat_rmax, stat_cmin, stat_cmax}, exp);
        end
        stat_sel = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ":rst_ctl"}, {sram_wen, busy, done, overflow, num_labels, sram_a},
              {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0});
        check({tag, ":rst_stat"}, {stat_label, stat_area, stat_rmin, stat_rmax, stat_cmin, stat_cmax}, 0);
    endtask

    // driver: one scan from a start pulse; E0 is the edge that samples start
    task automatic run_scan(input string tag, input int reset_at, input int restart_at);
        int  n;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ":e0"}, {busy, done, sram_a}, {1'b1, 1'b0, 10'd0});
        start = 1'b0;
        for (n = 1; n <= 1100; n++) begin
            start = (n == restart_at);
            reset = (n == reset_at);
            @(posedge clk);
            #1;
            if (n == reset_at) begin
                reset = 1'b0;
                start = 1'b0;
                check_reset_vals({tag, ":midrst"});
                return;
            end
            if (n == 700) check({tag, ":mid"}, {busy, done, sram_a}, {1'b1, 1'b0, 10'd700});
            if (done) break;
        end
        start = 1'b0;
        check({tag, ":latency"}, n, 1025);
        check({tag, ":end_flags"}, {busy, done}, {1'b0, 1'b1});
        build_ref();
        check_table(tag);
        repeat (3) @(posedge clk);
        #1;
        check({tag, ":hold"}, {busy, done, num_labels}, {1'b0, 1'b1, 6'(ref_n)});
    endtask

    task automatic fill_random(input int max_lbl, input int density);
        for (int a = 0; a < 1024; a++)
            mem[a] = ($urandom_range(0, 99) < density) ? 8'($urandom_range(1, max_lbl)) : 8'h00;
    endtask

    task automatic fill_zero();
        for (int a = 0; a < 1024; a++) mem[a] = 8'h00;
    endtask

    initial begin
        int r0, c0, h, w;
        reset    = 1'b1;
        start    = 1'b0;
        stat_sel = '0;
        fill_zero();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b0;

        run_scan("zero", -1, -1);

        fill_zero();
        mem[1023] = 8'h07;
        run_scan("corner", -1, -1);

        for (int a = 0; a < 1024; a++) mem[a] = 8'h01;
        run_scan("full", -1, -1);

        // five rectangular components in separate column bands
        fill_zero();
        for (int k = 0; k < 5; k++) begin
            h  = $urandom_range(1, 12);
            w  = $urandom_range(1, 6);
            r0 = $urandom_range(0, 32 - h);
            c0 = k * 6 + $urandom_range(0, 6 - w);
            for (int r = r0; r < r0 + h; r++)
                for (int c = c0; c < c0 + w; c++)
                    mem[r * 32 + c] = 8'(8'h20 + 8'(k * 13));
        end
        run_scan("rects", -1, -1);

        fill_zero();
        for (int i = 0; i < 33; i++) mem[i * 31] = 8'(i + 1);
        run_scan("ovf33", -1, -1);

        for (int t = 0; t < 3; t++) begin
            fill_random(12 + t * 14, 10 + t * 20);
            run_scan($sformatf("rand%0d", t), -1, -1);
        end

        fill_random(255, 30);
        run_scan("rnd_ovf", -1, -1);

        fill_random(20, 40);
        run_scan("abort", 500, 10);
        run_scan("rerun", -1, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cle_label_stats.md
# cle_label_stats

Post-labeling statistics engine downstream of `CLE`. When `CLE` asserts `finish`, this block scans the 1024-entry label SRAM (32x32 image, one 8-bit label per pixel, 0 = background). It builds a per-component table of label value, pixel area and bounding box, then exposes the table through a combinational select port for host or scoreboard readout. It shares `sram_1024x8` with `CLE`; the integration muxes SRAM ports to this block once `finish` is high.

## Interface
- `MAX_LABELS`, 32: number of table slots (distinct nonzero labels tracked).
- `SEL_W`, 5: width of `stat_sel`, equal to clog2(MAX_LABELS).

- `clk` in 1: single clock, rising-edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `start` in 1: begin scan; wired to `CLE` `finish`; level or pulse accepted.
- `sram_q` in 8: SRAM read data; valid the cycle after the address is sampled.
- `sram_a` out 10: SRAM address, registered; row = `sram_a[9:5]`, col = `sram_a[4:0]`.
- `sram_wen` out 1: constant 1 (read-only).
- `stat_sel` in SEL_W: slot select for readout.
- `stat_label` out 8: label value of the selected slot.
- `stat_area` out 11: pixel count of the selected slot (0..1024).
- `stat_rmin`, `stat_rmax`, `stat_cmin`, `stat_cmax` out 5 each: bounding box of the selected slot.
- `num_labels` out 6: number of allocated slots (0..MAX_LABELS).
- `overflow` out 1: more than MAX_LABELS distinct labels were seen.
- `busy` out 1: scan in progress.
- `done` out 1: table valid; held until the next `start` or `reset`.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
  - IDLE: `start` is 1 → SCAN; address counter = 0; table, `num_labels` and `overflow` cleared.
  - SCAN: `sram_a` increments by 1 per cycle from 0 to 1023. After 1023 is issued → DRAIN.
  - DRAIN: absorbs the remaining in-flight read data, then → DONE.
  - DONE: `start` is 1 → clear table, → SCAN (restart). Otherwise hold.
- Processing pipeline: address k is presented, SRAM samples it on the next edge, and `sram_q` = pixel k is processed on the edge after that. Row and column of k are delayed through the same 2-stage pipe.
- Per processed pixel value v:
  - v = 0: no action.
  - v matches a valid slot: area += 1; rmin/rmax/cmin/cmax updated by min/max with the pixel row/col.
  - no match and `num_labels` < MAX_LABELS: allocate slot `num_labels` with label = v, area = 1, bbox = the pixel point; `num_labels` += 1.
  - no match and table full: `overflow` set (sticky until restart or reset); pixel dropped.
- Slot order is first appearance in raster order (row-major, col fastest).
- Readout: `stat_sel` < `num_labels` → the slot's fields. Otherwise all `stat_*` are 0. Outputs are combinational from the table and meaningful only when `done` is 1.

## Timing
- Reset values: `sram_a` = 0, `sram_wen` = 1, `busy` = 0, `done` = 0, `overflow` = 0, `num_labels` = 0, all slots invalid with fields zeroed, state IDLE.
- Edge E0 samples `start` while in IDLE: `busy` = 1 and `sram_a` = 0 from E0. `sram_a` = k after E0+k.
- Pixel k is absorbed at edge E0+k+2. The last pixel is absorbed at E0+1025.
- At E0+1025: `done` = 1 and `busy` = 0. Total latency is 1025 cycles, fixed and independent of image content.
- `start` during SCAN or DRAIN: ignored.
- `start` and `reset` in the same cycle: `reset` wins.
- `reset` mid-scan: all outputs return to reset values at that edge. Any partial table is discarded.
- Match and allocate resolve in one cycle; there are no stalls. The same label in consecutive pixels updates correctly, because the read-modify-write completes within one edge.

## Structure
- Shared package `cle_pkg`:
  - constants IMG_W = 32, ADDR_W = 10, LABEL_W = 8, AREA_W = 11;
  - the state enum;
  - the slot struct {valid, label, area, rmin, rmax, cmin, cmax}.
- Sub-module `cle_label_cam`:
  - a MAX_LABELS-entry parallel label match;
  - returns hit, hit index and free index;
  - the top level owns the FSM, the pipeline and the bbox/area update.

## Test plan
- All-zero image, `start` pulse: `done` at E0+1025, `num_labels` = 0, `overflow` = 0, every `stat_*` = 0.
- Single pixel 0x07 at addr 1023: `num_labels` = 1; slot 0 reads label 0x07, area 1, bbox r 31..31, c 31..31.
- Every pixel = 0x01: slot 0 reads area 1024 (11-bit, no wrap), bbox 0..31 on both axes.
- Golden `sram_a.dat` image (5 components): `num_labels` = 5; areas and bboxes match a reference model computed from the file; slots are in raster first-appearance order.
- 33 distinct labels, one pixel each, with MAX_LABELS = 32: `num_labels` = 32, `overflow` = 1, 33rd label absent from the table.
- `reset` at E0+500, then a fresh `start`: outputs are at reset values after the reset edge, and the rerun matches a clean run. A second `start` pulse at E0+10 is ignored, giving identical results and timing.
